hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: operand forwarding, load-use stall and jump flush.
// Optional saturating stall/flush counters with HAZARD_STATS_EN.
module hazard_ctrl #(
    parameter int REG_ADDR_W  = 2,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_wr,
    input  logic                  id_rm,
    input  logic                  br_taken,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall,
    output logic [2:0]            flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           flush_cnt
`endif
);

    localparam logic [3:0] FLUSH_ONES = 4'((1 << FLUSH_DEPTH) - 1);
    localparam logic [2:0] FLUSH_MASK = FLUSH_ONES[2:0];

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  rm;
    } sb_t;

    // index 0 = EX, 1 = MEM, 2 = WB
    sb_t sb [3];
    sb_t ex_nxt;
    sb_t mem_nxt;
    logic load_use;

    function automatic logic [1:0] src_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  used,
        input sb_t                   ex,
        input sb_t                   mem
    );
        logic ex_hit;
        logic mem_hit;
        ex_hit  = used & ex.valid & ex.wr & (ex.rd == rs);
        mem_hit = used & mem.valid & mem.wr & (mem.rd == rs);
        if (ex_hit)
            return 2'b01;
        else if (mem_hit)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use = id_valid & sb[0].valid & sb[0].rm & sb[0].wr &
                   ((id_rs1_used & (sb[0].rd == id_rs1)) |
                    (id_rs2_used & (sb[0].rd == id_rs2)));
        stall = load_use & ~br_taken & ~reset;
        flush = (br_taken & ~reset) ? FLUSH_MASK : 3'b000;
    end

    always_comb begin
        ex_nxt       = '0;
        ex_nxt.valid = id_valid & ~stall & ~flush[1];
        ex_nxt.rd    = id_rd;
        ex_nxt.wr    = id_wr;
        ex_nxt.rm    = id_rm;
        mem_nxt       = sb[0];
        mem_nxt.valid = sb[0].valid & ~flush[2];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb[0] <= '0;
            sb[1] <= '0;
            sb[2] <= '0;
            fwd_a <= 2'b00;
            fwd_b <= 2'b00;
        end else begin
            sb[2] <= sb[1];
            sb[1] <= mem_nxt;
            sb[0] <= ex_nxt;
            // a taken jump leaves no stale forward into the squashed slot
            if (br_taken) begin
                fwd_a <= 2'b00;
                fwd_b <= 2'b00;
            end else begin
                fwd_a <= src_sel(id_rs1, id_rs1_used, sb[0], sb[1]);
                fwd_b <= src_sel(id_rs2, id_rs2_used, sb[0], sb[1]);
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= 16'h0000;
            flush_cnt <= 16'h0000;
        end else begin
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'h0001;
            if (br_taken && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against an in-flight history model.
// Counter checks are active when HAZARD_STATS_EN is defined.
module tb_hazard_ctrl;

    localparam int AW = 2;
    localparam int FD = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          id_rs1_used;
    logic          id_rs2_used;
    logic [AW-1:0] id_rd;
    logic          id_wr;
    logic          id_rm;
    logic          br_taken;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          stall;
    logic [2:0]    flush;
`ifdef HAZARD_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   flush_cnt;
`endif

    always #5 clock = ~clock;

    hazard_ctrl #(.REG_ADDR_W(AW), .FLUSH_DEPTH(FD)) dut (
        .clock       (clock),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .id_rd       (id_rd),
        .id_wr       (id_wr),
        .id_rm       (id_rm),
        .br_taken    (br_taken),
        .fwd_a       (fwd_a),
        .fwd_b       (fwd_b),
        .stall       (stall),
`ifdef HAZARD_STATS_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .flush       (flush)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: instructions that have entered EX, youngest first.
    typedef struct {
        bit valid;
        int rd;
        bit wr;
        bit rm;
    } ins_t;

    ins_t hist[$];
    int   m_sc = 0;
    int   m_fc = 0;
    logic last_stall;
    logic [2:0] last_flush;

    function automatic ins_t at(input int age);
        ins_t e;
        e = '{valid: 1'b0, rd: 0, wr: 1'b0, rm: 1'b0};
        if (age < hist.size()) e = hist[age];
        return e;
    endfunction

    // age 0 (result in EX/MEM) -> 1, age 1 (data in MEM/WB) -> 2
    function automatic int fwd_of(input int rs, input bit used);
        ins_t e;
        if (!used) return 0;
        for (int age = 0; age < 2; age++) begin
            e = at(age);
            if (e.valid && e.wr && e.rd == rs) return age + 1;
        end
        return 0;
    endfunction

    task automatic cyc(input bit v, input int rs1, input bit u1,
                       input int rs2, input bit u2, input int rd,
                       input bit wr, input bit rm, input bit br,
                       input bit rst, input string tag);
        ins_t e0;
        ins_t n;
        bit   es;
        int   ef;
        int   nfa;
        int   nfb;
        reset       = rst;
        id_valid    = v;
        id_rs1      = AW'(rs1);
        id_rs2      = AW'(rs2);
        id_rs1_used = u1;
        id_rs2_used = u2;
        id_rd       = AW'(rd);
        id_wr       = wr;
        id_rm       = rm;
        br_taken    = br;
        #1;
        e0 = at(0);
        es = v && e0.valid && e0.rm && e0.wr &&
             ((u1 && e0.rd == rs1) || (u2 && e0.rd == rs2)) && !br && !rst;
        ef = (rst || !br) ? 0 : (1 << FD) - 1;
        last_stall = stall;
        last_flush = flush;
        check({tag, ".stall"}, 32'(stall), 32'(es));
        check({tag, ".flush"}, 32'(flush), 32'(ef));
        nfa = (rst || br) ? 0 : fwd_of(rs1, u1);
        nfb = (rst || br) ? 0 : fwd_of(rs2, u2);
        if (rst) begin
            hist.delete();
            m_sc = 0;
            m_fc = 0;
        end else begin
            if (hist.size() > 0 && br && FD >= 3) hist[0].valid = 1'b0;
            n = '{valid: v && !es && !(br && FD >= 2), rd: rd, wr: wr, rm: rm};
            hist.push_front(n);
            while (hist.size() > 3) void'(hist.pop_back());
            if (es && m_sc < 65535) m_sc++;
            if (br && m_fc < 65535) m_fc++;
        end
        @(posedge clock);
        #1;
        check({tag, ".fwd_a"}, 32'(fwd_a), 32'(nfa));
        check({tag, ".fwd_b"}, 32'(fwd_b), 32'(nfb));
`ifdef HAZARD_STATS_EN
        check({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(m_sc));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), 32'(m_fc));
`endif
    endtask

    task automatic nop(input string tag);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rst0");
        cyc(1, 1, 1, 2, 1, 3, 1, 1, 1, 1, "rst1");
        check("rst.fwd_a", 32'(fwd_a), 32'd0);

        // back-to-back ALU
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, "add");
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, "sub");
        check("b2b.fwd_a", 32'(fwd_a), 32'd1);
        check("b2b.stall", 32'(last_stall), 32'd0);

        // one instruction apart
        cyc(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, "wr2");
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "gap");
        cyc(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, "rd2");
        check("apart.fwd_b", 32'(fwd_b), 32'd2);

        // load-use
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, "ld3");
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, "use3a");
        check("lu.stall1", 32'(last_stall), 32'd1);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, "use3b");
        check("lu.stall2", 32'(last_stall), 32'd0);
        check("lu.fwd_a", 32'(fwd_a), 32'd2);
        nop("lu.after");
        check("lu.stall3", 32'(last_stall), 32'd0);

        // taken jump squashes a writer
        nop("pre_br");
        cyc(1, 0, 0, 0, 0, 1, 1, 0, 1, 0, "br");
        check("br.flush", 32'(last_flush), 32'd3);
        cyc(1, 1, 1, 1, 1, 0, 0, 0, 0, 0, "br.next");
        check("br.flush0", 32'(last_flush), 32'd0);
        check("br.nofwd", 32'(fwd_a), 32'd0);

        // jump and load-use together
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, "ld3b");
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, "lu_br");
        check("lubr.stall", 32'(last_stall), 32'd0);
        check("lubr.flush", 32'(last_flush), 32'd3);

        // reset during a load-use stall
        cyc(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, "ld3c");
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 1, "lu_rst");
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, "post_rst");
        check("rst.stall", 32'(last_stall), 32'd0);
        check("rst.fwd", 32'(fwd_a), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 7) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 63) == 0, "rnd");
        end

`ifdef HAZARD_STATS_EN
        for (int i = 0; i < 65540; i++) begin
            id_valid = 1'b0;
            br_taken = 1'b1;
            reset    = 1'b0;
            @(posedge clock);
            #1;
        end
        check("sat.flush_cnt", 32'(flush_cnt), 32'hFFFF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "sat.rst");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
